// File: rtl/branch_predict_scheduler_pkg.sv
// Shared definitions for the hybrid branch-predictor scheduler: chooser
// counter encodings, scheduler FSM states and queue entry layout.
package branch_predict_scheduler_pkg;

    // Chooser counter: values 0/1 trust the local predictor, 2/3 the global one.
    localparam logic [1:0] STRONG_LOCAL  = 2'b00;
    localparam logic [1:0] WEAK_LOCAL    = 2'b01;
    localparam logic [1:0] WEAK_GLOBAL   = 2'b10;
    localparam logic [1:0] STRONG_GLOBAL = 2'b11;
    localparam logic [1:0] CHOOSER_RESET = WEAK_GLOBAL;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        TRAIN = 2'd2
    } sched_state_t;

    // Queue entry is {addr, global_taken, local_taken, chosen}; these are the
    // positions of the three flag bits below the address.
    localparam int FLAG_W      = 3;
    localparam int FLAG_GLOBAL = 2;
    localparam int FLAG_LOCAL  = 1;
    localparam int FLAG_CHOSEN = 0;

    // Move the chooser towards whichever predictor alone was right; when both
    // or neither were right the chooser learns nothing.
    function automatic logic [1:0] chooser_next(input logic [1:0] cur,
                                                input logic       global_ok,
                                                input logic       local_ok);
        logic [1:0] nxt;
        nxt = cur;
        if (global_ok && !local_ok && cur != STRONG_GLOBAL) begin
            nxt = cur + 2'd1;
        end else if (local_ok && !global_ok && cur != STRONG_LOCAL) begin
            nxt = cur - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predict_scheduler_queue.sv
// In-order FIFO of in-flight branches. Flush empties it on the next edge and
// wins over push and pop; the head is still readable in a flushing cycle so
// a simultaneous pop sees the oldest entry.
module branch_queue
    import branch_predict_scheduler_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = 32 + FLAG_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset; only slots behind the write pointer are read.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/branch_predict_scheduler.sv
// Hybrid predictor controller: picks global or local prediction through a
// per-PC chooser table, queues in-flight branches, and on each resolution
// issues one update to the predictors and then trains the chooser.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. Pred_ready and Resolve_ready never depend on their own valid; the
// Upd_valid/Upd_addr/Upd_taken bundle is held stable until Upd_ready is seen.
module branch_predict_scheduler
    import branch_predict_scheduler_pkg::*;
#(
    parameter int QUEUE_DEPTH  = 8,
    parameter int CHOOSER_BITS = 8,
    parameter int ADDR_W       = 32
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic                           Pred_valid,
    input  logic [ADDR_W-1:0]              Pred_addr,
    input  logic                           Global_taken,
    input  logic                           Local_taken,
    output logic                           Taken,
    output logic                           Pred_ready,
    input  logic                           Resolve_valid,
    input  logic                           Resolve_taken,
    output logic                           Resolve_ready,
    input  logic                           Flush,
    output logic                           Upd_valid,
    input  logic                           Upd_ready,
    output logic [ADDR_W-1:0]              Upd_addr,
    output logic                           Upd_taken,
    output logic                           Mispredict,
    output logic [1:0]                     dbg_state,
    output logic [$clog2(QUEUE_DEPTH):0]   dbg_count
);

    localparam int ENTRY_W = ADDR_W + FLAG_W;
    localparam int CH_N    = 1 << CHOOSER_BITS;

    sched_state_t              state_q;
    sched_state_t              state_d;
    logic [1:0]                chooser_q [CH_N];
    logic [CHOOSER_BITS-1:0]   pred_idx;
    logic [CHOOSER_BITS-1:0]   upd_idx;
    logic                      q_full;
    logic                      q_empty;
    logic                      push;
    logic                      accept;
    logic [ENTRY_W-1:0]        push_entry;
    logic [ENTRY_W-1:0]        head_entry;
    logic                      upd_global_ok;
    logic                      upd_local_ok;

    assign pred_idx   = Pred_addr[CHOOSER_BITS+1:2];
    assign upd_idx    = Upd_addr[CHOOSER_BITS+1:2];

    // Chooser read has no bypass from a same-cycle TRAIN write.
    assign Taken      = Pred_valid && !q_full &&
                        (chooser_q[pred_idx][1] ? Global_taken : Local_taken);
    assign Pred_ready = !q_full;
    assign push       = Pred_valid && Pred_ready && !Flush;
    assign push_entry = {Pred_addr, Global_taken, Local_taken, Taken};

    assign Resolve_ready = (state_q == IDLE) && !q_empty;
    assign accept        = Resolve_valid && Resolve_ready;
    assign dbg_state     = state_q;

    branch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .W     (ENTRY_W)
    ) u_queue (
        .clk   (CLK),
        .rst   (RESET),
        .push  (push),
        .pop   (accept),
        .flush (Flush),
        .wdata (push_entry),
        .rdata (head_entry),
        .full  (q_full),
        .empty (q_empty),
        .count (dbg_count)
    );

    // Scheduler state register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state and the update request strobe.
    always_comb begin
        state_d   = state_q;
        Upd_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = REQ;
            end
            REQ: begin
                Upd_valid = 1'b1;
                if (Upd_ready) state_d = TRAIN;
            end
            TRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Capture the popped head and actual outcome; Mispredict is a one-cycle pulse.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            Upd_addr      <= '0;
            Upd_taken     <= 1'b0;
            upd_global_ok <= 1'b0;
            upd_local_ok  <= 1'b0;
            Mispredict    <= 1'b0;
        end else begin
            Mispredict <= 1'b0;
            if (accept) begin
                Upd_addr      <= head_entry[ENTRY_W-1:FLAG_W];
                Upd_taken     <= Resolve_taken;
                upd_global_ok <= (head_entry[FLAG_GLOBAL] == Resolve_taken);
                upd_local_ok  <= (head_entry[FLAG_LOCAL] == Resolve_taken);
                Mispredict    <= (head_entry[FLAG_CHOSEN] != Resolve_taken);
            end
        end
    end

    // Chooser table: reset to weakly-global, trained once per update in TRAIN.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < CH_N; i++) chooser_q[i] <= CHOOSER_RESET;
        end else if (state_q == TRAIN) begin
            chooser_q[upd_idx] <= chooser_next(chooser_q[upd_idx], upd_global_ok, upd_local_ok);
        end
    end

endmodule

// File: tb/tb_branch_predict_scheduler.sv
// Directed bench for branch_predict_scheduler: reference chooser model plus
// an expected queue of in-flight entries {addr, global, local, chosen}.
module tb_branch_predict_scheduler;
    import branch_predict_scheduler_pkg::*;

    localparam int ADDR_W  = 32;
    localparam int DEPTH   = 8;
    localparam int ENTRY_W = ADDR_W + 3;

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic              Pred_valid = 1'b0;
    logic [ADDR_W-1:0] Pred_addr = '0;
    logic              Global_taken = 1'b0;
    logic              Local_taken = 1'b0;
    logic              Taken;
    logic              Pred_ready;
    logic              Resolve_valid = 1'b0;
    logic              Resolve_taken = 1'b0;
    logic              Resolve_ready;
    logic              Flush = 1'b0;
    logic              Upd_valid;
    logic              Upd_ready = 1'b1;
    logic [ADDR_W-1:0] Upd_addr;
    logic              Upd_taken;
    logic              Mispredict;
    logic [1:0]        dbg_state;
    logic [3:0]        dbg_count;

    logic [ENTRY_W-1:0] exp_q[$];
    logic [1:0]         model_ch [256];
    int                 cmp_cnt = 0;
    int                 err_cnt = 0;

    branch_predict_scheduler dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .Pred_valid    (Pred_valid),
        .Pred_addr     (Pred_addr),
        .Global_taken  (Global_taken),
        .Local_taken   (Local_taken),
        .Taken         (Taken),
        .Pred_ready    (Pred_ready),
        .Resolve_valid (Resolve_valid),
        .Resolve_taken (Resolve_taken),
        .Resolve_ready (Resolve_ready),
        .Flush         (Flush),
        .Upd_valid     (Upd_valid),
        .Upd_ready     (Upd_ready),
        .Upd_addr      (Upd_addr),
        .Upd_taken     (Upd_taken),
        .Mispredict    (Mispredict),
        .dbg_state     (dbg_state),
        .dbg_count     (dbg_count)
    );

    // Clock
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < 256; i++) model_ch[i] = 2'b10;
    endtask

    // Present a prediction for one cycle; it is queued if the queue has room.
    task automatic predict(input logic [31:0] addr, input logic g, input logic l);
        logic       exp_t;
        logic [7:0] idx;
        idx = addr[9:2];
        Pred_valid = 1'b1; Pred_addr = addr; Global_taken = g; Local_taken = l;
        #1;
        exp_t = (exp_q.size() < DEPTH) && (model_ch[idx][1] ? g : l);
        check("pred_ready", Pred_ready, exp_q.size() < DEPTH);
        check("taken", Taken, exp_t);
        if (exp_q.size() < DEPTH) exp_q.push_back({addr, g, l, exp_t});
        tick();
        Pred_valid = 1'b0;
    endtask

    // Look at Taken without letting the prediction enter the queue.
    task automatic peek_taken(input logic [31:0] addr, input logic g, input logic l,
                              input logic exp_t);
        Pred_valid = 1'b1; Pred_addr = addr; Global_taken = g; Local_taken = l;
        #1;
        check("peek_taken", Taken, exp_t);
        Pred_valid = 1'b0;
        #1;
    endtask

    // Resolve the oldest entry, optionally stalling Upd_ready and/or flushing.
    task automatic resolve(input logic actual, input int stall, input logic flush);
        logic [ENTRY_W-1:0] head;
        logic [31:0]        a;
        logic               g, l, c;
        logic [7:0]         idx;
        check("resolve_ready_pre", Resolve_ready, exp_q.size() != 0);
        if (exp_q.size() == 0) return;
        Resolve_valid = 1'b1; Resolve_taken = actual; Flush = flush;
        Upd_ready = (stall == 0);
        tick();
        Resolve_valid = 1'b0; Flush = 1'b0;
        head = exp_q.pop_front();
        if (flush) exp_q.delete();
        {a, g, l, c} = head;
        check("upd_valid_req", Upd_valid, 1'b1);
        check("upd_addr", Upd_addr, a);
        check("upd_taken", Upd_taken, actual);
        check("mispredict", Mispredict, c != actual);
        for (int i = 0; i < stall; i++) begin
            tick();
            check("stall_upd_valid", Upd_valid, 1'b1);
            check("stall_upd_addr", Upd_addr, a);
            check("stall_upd_taken", Upd_taken, actual);
            check("stall_resolve_ready", Resolve_ready, 1'b0);
            check("stall_mispredict", Mispredict, 1'b0);
        end
        Upd_ready = 1'b1;
        tick();
        check("train_state", dbg_state, TRAIN);
        check("train_upd_valid", Upd_valid, 1'b0);
        check("train_resolve_ready", Resolve_ready, 1'b0);
        check("train_mispredict", Mispredict, 1'b0);
        idx = a[9:2];
        if (g == actual && l != actual && model_ch[idx] != 2'd3) model_ch[idx] = model_ch[idx] + 2'd1;
        else if (l == actual && g != actual && model_ch[idx] != 2'd0) model_ch[idx] = model_ch[idx] - 2'd1;
        tick();
        check("idle_state", dbg_state, IDLE);
        check("chooser", dut.chooser_q[idx], model_ch[idx]);
        check("resolve_ready_post", Resolve_ready, exp_q.size() != 0);
    endtask

    initial begin
        // Reset
        model_reset();
        repeat (2) tick();
        RESET = 1'b0;
        tick();
        check("rst_pred_ready", Pred_ready, 1'b1);
        check("rst_resolve_ready", Resolve_ready, 1'b0);
        check("rst_upd_valid", Upd_valid, 1'b0);
        check("rst_upd_addr", Upd_addr, 32'h0);
        check("rst_upd_taken", Upd_taken, 1'b0);
        check("rst_mispredict", Mispredict, 1'b0);
        check("rst_state", dbg_state, IDLE);
        check("rst_chooser", dut.chooser_q[8'h10], 2'b10);

        // Basic mispredict: global says taken, branch falls through
        predict(32'h40, 1'b1, 1'b0);
        resolve(1'b0, 0, 1'b0);
        check("ch_0x10_after", dut.chooser_q[8'h10], 2'b01);
        peek_taken(32'h40, 1'b1, 1'b0, 1'b0);

        // Fill queue, overflow attempt, drain in order
        for (int i = 0; i < DEPTH; i++) predict(32'h100 + 32'(i * 4), i[0], ~i[0]);
        check("full_pred_ready", Pred_ready, 1'b0);
        check("full_count", dbg_count, 4'd8);
        predict(32'h200, 1'b1, 1'b1);
        check("overflow_count", dbg_count, 4'd8);
        for (int i = 0; i < DEPTH; i++) resolve(i[0], 0, 1'b0);
        check("drained_pred_ready", Pred_ready, 1'b1);
        check("drained_count", dbg_count, 4'd0);

        // Upd_ready stall for 5 cycles with another branch waiting
        predict(32'h300, 1'b0, 1'b0);
        predict(32'h304, 1'b0, 1'b0);
        resolve(1'b1, 5, 1'b0);
        resolve(1'b0, 0, 1'b0);

        // Chooser saturation up then down
        for (int k = 0; k < 4; k++) begin
            predict(32'h800, 1'b1, 1'b0);
            resolve(1'b1, 0, 1'b0);
        end
        check("sat_high", dut.chooser_q[8'h00], 2'b11);
        for (int k = 0; k < 4; k++) begin
            predict(32'h800, 1'b1, 1'b0);
            resolve(1'b0, 0, 1'b0);
        end
        check("sat_low", dut.chooser_q[8'h00], 2'b00);

        // Flush together with accept
        predict(32'h900, 1'b1, 1'b0);
        predict(32'h904, 1'b0, 1'b1);
        predict(32'h908, 1'b1, 1'b1);
        resolve(1'b1, 0, 1'b1);
        check("flush_resolve_ready", Resolve_ready, 1'b0);
        check("flush_count", dbg_count, 4'd0);

        // Flush together with push discards the push
        predict(32'hA00, 1'b1, 1'b0);
        Pred_valid = 1'b1; Pred_addr = 32'hA04; Flush = 1'b1;
        tick();
        Pred_valid = 1'b0; Flush = 1'b0;
        exp_q.delete();
        check("flush_push_count", dbg_count, 4'd0);
        check("flush_push_resolve_ready", Resolve_ready, 1'b0);

        // RESET while a request is pending
        predict(32'h40, 1'b1, 1'b0);
        predict(32'h44, 1'b1, 1'b0);
        Upd_ready = 1'b0; Resolve_valid = 1'b1; Resolve_taken = 1'b0;
        tick();
        Resolve_valid = 1'b0;
        check("pre_rst_upd_valid", Upd_valid, 1'b1);
        #2 RESET = 1'b1;
        #1;
        check("midrst_upd_valid", Upd_valid, 1'b0);
        check("midrst_resolve_ready", Resolve_ready, 1'b0);
        check("midrst_count", dbg_count, 4'd0);
        check("midrst_state", dbg_state, IDLE);
        check("midrst_upd_addr", Upd_addr, 32'h0);
        check("midrst_chooser_10", dut.chooser_q[8'h10], 2'b10);
        check("midrst_chooser_00", dut.chooser_q[8'h00], 2'b10);
        model_reset();
        tick();
        RESET = 1'b0; Upd_ready = 1'b1;
        tick();
        peek_taken(32'h40, 1'b1, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/branch_predict_scheduler.md
Name: branch_predict_scheduler

Overview:
- Hybrid-predictor controller that sits between fetch/decode and the global and local 2-bit predictors.
- Selects which predictor's prediction drives Taken, using a per-PC 2-bit chooser table.
- Tracks in-flight conditional branches in an in-order queue.
- On each branch resolution, sequences the update handshake to the predictors and then trains the chooser.

Parameters:
- QUEUE_DEPTH, 8: in-flight branch entries (power of 2).
- CHOOSER_BITS, 8: chooser index width. Table holds 2^CHOOSER_BITS entries, indexed by Pred_addr[CHOOSER_BITS+1:2].
- ADDR_W, 32: instruction address width.

Ports:
- CLK  in  1  clock, all state on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- Pred_valid  in  1  a conditional branch is being predicted this cycle.
- Pred_addr  in  ADDR_W  address of the predicted branch.
- Global_taken  in  1  global predictor's prediction for Pred_addr.
- Local_taken  in  1  local predictor's prediction for Pred_addr.
- Taken  out  1  chosen prediction (combinational).
- Pred_ready  out  1  queue not full.
- Resolve_valid  in  1  oldest in-flight branch is resolved.
- Resolve_taken  in  1  actual outcome.
- Resolve_ready  out  1  scheduler can accept a resolution.
- Flush  in  1  discard all unresolved entries.
- Upd_valid  out  1  update request to both predictors.
- Upd_ready  in  1  predictors accept the update.
- Upd_addr  out  ADDR_W  address for the update.
- Upd_taken  out  1  outcome for the update.
- Mispredict  out  1  one-cycle pulse: chosen prediction was wrong.

Behaviour:
- Reset (asynchronous, active-high, CLK domain):
  - Queue empty; FSM in IDLE.
  - All chooser entries = 2'b10 (weakly global).
  - Upd_valid = 0, Upd_addr = 0, Upd_taken = 0, Mispredict = 0.
  - Pred_ready = 1, Resolve_ready = 0 (queue empty).
- Taken:
  - Chooser[idx] >= 2 selects Global_taken, otherwise Local_taken.
  - Taken = 0 when Pred_valid = 0 or the queue is full.
- Push:
  - Occurs when Pred_valid && Pred_ready && !Flush.
  - Entry stores {addr, Global_taken, Local_taken, Taken}.
  - Pred_valid while full: no push, Taken = 0, no error.
- Resolve_ready = (state == IDLE) && !empty.
- Accept occurs when Resolve_valid && Resolve_ready:
  - Head is popped into the update registers.
  - Mispredict pulses next cycle iff Resolve_taken != head.chosen.
  - Resolve_valid while not ready: ignored.
- Simultaneous push and pop: both occur; count unchanged. Pointers wrap modulo QUEUE_DEPTH.
- FSM:
  - IDLE -> REQ on accept.
  - REQ: Upd_valid = 1 with registered Upd_addr/Upd_taken, held stable until Upd_ready. REQ -> TRAIN in the cycle Upd_ready = 1. Upd_valid is deasserted the following cycle.
  - TRAIN, one cycle, chooser[idx(Upd_addr)] written:
    - global correct and local wrong: saturating increment (max 3).
    - local correct and global wrong: saturating decrement (min 0).
    - otherwise: unchanged.
  - TRAIN -> IDLE.
  - Minimum resolve-to-resolve spacing is 3 cycles.
- Chooser read in the same cycle as a TRAIN write to the same index returns the old value (no bypass).
- Flush:
  - Next edge: queue emptied (pointers reset).
  - An update already in REQ/TRAIN completes normally.
  - Flush with push in the same cycle: push discarded.
  - Flush with accept in the same cycle: accept proceeds on the head; the remainder is flushed.
- RESET mid-operation: everything returns to reset values immediately; a pending Upd_valid is dropped.

Decomposition:
- Shared package:
  - chooser state constants (STRONG_LOCAL = 0 .. STRONG_GLOBAL = 3, RESET value 2'b10).
  - FSM state encoding IDLE/REQ/TRAIN.
  - queue entry field widths.
- One sub-module: branch_queue. Parameterised in-order FIFO with push, pop and flush, and full/empty/count outputs.
- Chooser table and FSM live in the top module.

Test Plan:
- Reset, then predict addr 0x40 with Global_taken = 1, Local_taken = 0 -> Taken = 1. Resolve not-taken with Upd_ready = 1 -> Upd_valid one cycle with addr 0x40, taken 0. Mispredict pulses. Chooser[0x10] becomes 2'b01. Next predict of 0x40 -> Taken = 0.
- Push 8 branches without resolving -> Pred_ready = 0. 9th Pred_valid -> Taken = 0, not queued. Resolve all 8 -> exactly 8 updates in push order, addresses match.
- Hold Upd_ready = 0 for 5 cycles -> Upd_valid, Upd_addr and Upd_taken stay stable, Resolve_ready = 0. Upd_ready = 1 -> TRAIN, then IDLE.
- Train the same address 4 times, global correct / local wrong -> chooser saturates at 3. Then 4 times local correct -> chooser reaches 0 with no wrap.
- Queue 3 entries, assert Flush together with Resolve_valid -> head updated, queue empty afterwards, Resolve_ready = 0.
- Assert RESET while in REQ -> Upd_valid = 0 immediately, queue empty, chooser entries = 2'b10.
